// File: rtl/nibble_deserializer_if.sv
// Bus bundle for the serial-to-parallel front end: serial stimulus in, assembled word and status out.
interface nibble_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             start;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic [7:0]       frame_count;

  modport master (
    output enable, start, serial_in,
    input  data_out, valid, busy, frame_count
  );

  modport slave (
    input  enable, start, serial_in,
    output data_out, valid, busy, frame_count
  );
endinterface

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel front end: collects WIDTH bits per frame, presents the word with a one-cycle
// valid strobe and keeps a wrapping count of completed frames.
module nibble_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  nibble_deserializer_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic             load_s;
  logic [WIDTH-1:0] data_out_r;
  logic             valid_r;
  logic             busy_r;
  logic [7:0]       frame_count_r;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic bit_in);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], bit_in};
    end else begin
      return {bit_in, cur[WIDTH-1:1]};
    end
  endfunction

  // Next-state, shift and word-completion decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shreg_nxt_s = shreg_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && bus.enable) begin
          shreg_nxt_s = shift_in({WIDTH{1'b0}}, bus.serial_in);
          cnt_nxt_s   = CNT_W'(1);
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (bus.enable) begin
          shreg_nxt_s = shift_in(shreg_r, bus.serial_in);
          cnt_nxt_s   = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            load_s      = 1'b1;
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        // Back-to-back frames: a start here is bit 1 of the next word.
        if (bus.start && bus.enable) begin
          shreg_nxt_s = shift_in({WIDTH{1'b0}}, bus.serial_in);
          cnt_nxt_s   = CNT_W'(1);
          state_nxt_s = SHIFT;
        end else begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = IDLE;
        end
      end
      default: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      shreg_r       <= {WIDTH{1'b0}};
      data_out_r    <= {WIDTH{1'b0}};
      valid_r       <= 1'b0;
      busy_r        <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      shreg_r <= shreg_nxt_s;
      valid_r <= (state_nxt_s == DONE);
      busy_r  <= (state_nxt_s == SHIFT);
      if (load_s) begin
        data_out_r    <= shreg_nxt_s;
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        data_out_r    <= data_out_r;
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.valid       = valid_r;
  assign bus.busy        = busy_r;
  assign bus.frame_count = frame_count_r;
endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench: two instances (MSB-first and LSB-first) share one stimulus stream; a scoreboard checks each word.
module tb_nibble_deserializer;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  nibble_deserializer_if #(.WIDTH(4)) a_if ();
  nibble_deserializer_if #(.WIDTH(4)) b_if ();

  assign b_if.enable    = a_if.enable;
  assign b_if.start     = a_if.start;
  assign b_if.serial_in = a_if.serial_in;

  nibble_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(a_if.slave));
  nibble_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (.clock(clock), .reset(reset), .bus(b_if.slave));

  typedef struct {
    logic [3:0] data;
    logic [7:0] fc;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] fc_exp = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every valid strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && a_if.valid) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_data", 32'(a_if.data_out), 32'(e.data));
        check("a_count", 32'(a_if.frame_count), 32'(e.fc));
      end
    end
    if (!reset && b_if.valid) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_data", 32'(b_if.data_out), 32'(e.data));
        check("b_count", 32'(b_if.frame_count), 32'(e.fc));
      end
    end
  end

  // bits[3] is sent first; stall_len idle-enable cycles are inserted before bit index stall_at.
  task automatic send(input logic [3:0] bits, input int stall_at, input int stall_len, input int repulse_at);
    logic [3:0] rev;
    for (int j = 0; j < 4; j++) rev[j] = bits[3-j];
    fc_exp = fc_exp + 8'd1;
    qa.push_back('{data: bits, fc: fc_exp});
    qb.push_back('{data: rev,  fc: fc_exp});
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          a_if.enable    = 1'b0;
          a_if.start     = 1'($urandom);
          a_if.serial_in = 1'($urandom);
          tick();
          check("stall_busy", 32'(a_if.busy), 32'd1);
          check("stall_valid", 32'(a_if.valid), 32'd0);
        end
      end
      a_if.enable    = 1'b1;
      a_if.start     = (i == 0) || (i == repulse_at);
      a_if.serial_in = bits[3-i];
      tick();
      if (i < 3) begin
        check("shift_busy", 32'(a_if.busy), 32'd1);
        check("shift_valid", 32'(a_if.valid), 32'd0);
      end else begin
        check("done_busy", 32'(a_if.busy), 32'd0);
        check("done_valid", 32'(a_if.valid), 32'd1);
        check("done_valid_b", 32'(b_if.valid), 32'd1);
      end
    end
    a_if.start = 1'b0;
  endtask

  initial begin
    a_if.enable    = 1'b0;
    a_if.start     = 1'b0;
    a_if.serial_in = 1'b0;

    // Reset with random inputs for two edges.
    for (int k = 0; k < 2; k++) begin
      a_if.enable    = 1'($urandom);
      a_if.start     = 1'($urandom);
      a_if.serial_in = 1'($urandom);
      tick();
    end
    reset = 1'b0;
    a_if.enable = 1'b1;
    a_if.start  = 1'b0;
    check("rst_data", 32'(a_if.data_out), 32'd0);
    check("rst_valid", 32'(a_if.valid), 32'd0);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_count", 32'(a_if.frame_count), 32'd0);

    // Basic frame.
    send(4'b1011, -1, 0, -1);
    tick();
    check("idle_valid", 32'(a_if.valid), 32'd0);
    check("hold_data", 32'(a_if.data_out), 32'hb);

    // Same frame stalled two cycles after bit 2.
    send(4'b1011, 2, 2, -1);
    tick();
    check("idle_valid2", 32'(a_if.valid), 32'd0);

    // Start re-pulsed mid-frame, then chained frame started in DONE.
    send(4'b1011, -1, 0, 2);
    send(4'b0110, -1, 0, -1);
    tick();
    check("chain_count", 32'(a_if.frame_count), 32'd4);
    check("chain_data", 32'(a_if.data_out), 32'h6);
    check("chain_idle_valid", 32'(a_if.valid), 32'd0);

    // Mid-frame reset after two bits.
    a_if.enable = 1'b1; a_if.start = 1'b1; a_if.serial_in = 1'b1;
    tick();
    a_if.start = 1'b0; a_if.serial_in = 1'b1;
    tick();
    reset = 1'b1; a_if.start = 1'b1;
    tick();
    reset = 1'b0; a_if.start = 1'b0;
    fc_exp = 8'd0;
    check("mrst_busy", 32'(a_if.busy), 32'd0);
    check("mrst_valid", 32'(a_if.valid), 32'd0);
    check("mrst_data", 32'(a_if.data_out), 32'd0);
    check("mrst_count", 32'(a_if.frame_count), 32'd0);
    tick();
    check("mrst_still_idle", 32'(a_if.busy), 32'd0);
    send(4'b1100, -1, 0, -1);
    tick();

    // 1,0,0,0: LSB-first instance must present 0001.
    send(4'b1000, -1, 0, -1);
    check("lsb_first_word", 32'(b_if.data_out), 32'h1);
    check("msb_first_word", 32'(a_if.data_out), 32'h8);

    // Run the count to 256 completed frames since reset.
    for (int f = 0; f < 254; f++) begin
      send(4'($urandom), -1, 0, -1);
    end
    tick();
    check("wrap_count", 32'(a_if.frame_count), 32'd0);
    check("wrap_count_b", 32'(b_if.frame_count), 32'd0);
    tick();
    check("sb_empty_a", 32'(qa.size()), 32'd0);
    check("sb_empty_b", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
